dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Controller FSM for the direct-mapped, write-back, write-allocate data cache.
- Sits upstream of the cache data and tag arrays and drives their index/write-enable and write ports.
- Accepts one CPU load/store at a time and arbitrates line fills and dirty writebacks with the memory side.
- Array contents are reset by the top level, not by this block.

Parameters:
- INDEX_BITS, 2, line index width (4 lines).
- OFFSET_BITS, 4, byte offset within a 128-bit line.
- ADDR_BITS, 32, CPU/memory address width.
- TAG_BITS is derived: ADDR_BITS-INDEX_BITS-OFFSET_BITS = 26.

Ports:
- clock  in  1  single clock, all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- cpu_req_valid  in  1  request present; sampled only in IDLE.
- cpu_req_rw  in  1  1=store, 0=load.
- cpu_req_addr  in  32  byte address; word select is addr[3:2].
- cpu_req_data  in  32  store data.
- cpu_res_data  out  32  load data, valid while cpu_res_ready=1.
- cpu_res_ready  out  1  one-cycle completion pulse.
- mem_req_valid  out  1  memory request, held until mem_data_ready.
- mem_req_rw  out  1  1=writeback, 0=fill.
- mem_req_addr  out  32  line-aligned address (low 4 bits zero).
- mem_req_data  out  128  writeback line.
- mem_data_ready  in  1  memory done (write accepted or fill data valid).
- mem_data  in  128  fill line.
- data_req  out  cache_req_type  {index, we} to data array.
- data_write  out  128  line to write.
- data_read  in  128  combinational read of data_req.index.
- tag_req  out  cache_req_type  {index, we} to tag array.
- tag_write  out  cache_tag_type  {valid, dirty, tag}.
- tag_read  in  cache_tag_type  combinational read.

Behaviour:
- States: IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE.
- Reset (reset_n=0 at posedge): state=IDLE, latched request cleared, all outputs 0. Reset mid-transaction abandons it; mem_req_valid drops the next cycle.
- IDLE: if cpu_req_valid, latch rw/addr/data and go to COMPARE_TAG. No other outputs asserted.
- COMPARE_TAG: index = latched addr[5:4]. Hit = tag_read.valid && tag_read.tag == addr[31:6].
  - Load hit: cpu_res_data = data_read word[addr[3:2]]; cpu_res_ready=1; go to IDLE.
  - Store hit: data_write = data_read with word[addr[3:2]] replaced; data_req.we=1; tag_write={1,1,tag}; tag_req.we=1; cpu_res_ready=1; go to IDLE.
  - Miss with valid && dirty: go to WRITE_BACK. Other misses: go to ALLOCATE.
- WRITE_BACK: mem_req_valid=1, rw=1, addr={tag_read.tag, index, 4'b0}, data=data_read. All held stable. On mem_data_ready go to ALLOCATE.
- ALLOCATE: mem_req_valid=1, rw=0, addr={req tag, index, 4'b0}.
  - On mem_data_ready: data_write=mem_data with data we=1; tag_write={1,0,req tag} with tag we=1; go to COMPARE_TAG.
  - The retry then hits.
- Latency: hit completes 2 cycles after acceptance (IDLE, COMPARE). Clean miss = 3 + fill wait. Dirty miss adds writeback wait.
- cpu_req_valid is ignored outside IDLE. cpu_res_ready is never asserted in WRITE_BACK or ALLOCATE.
- mem_data_ready outside WRITE_BACK/ALLOCATE is ignored.
- Back-to-back requests: the earliest next acceptance is the cycle after cpu_res_ready.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Enabled:
  - Adds outputs stat_hits[31:0], stat_misses[31:0] and stat_writebacks[31:0].
  - hits increments on each first-pass COMPARE hit. The post-fill retry is not counted as a hit.
  - misses increments on each COMPARE miss.
  - writebacks increments on each WRITE_BACK exit.
  - All counters wrap at 2^32 and clear on reset.
- Disabled: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- cache_def_pkg holds:
  - cache_req_type {index[INDEX_BITS-1:0], we}.
  - cache_tag_type {valid, dirty, tag[TAG_BITS-1:0]}.
  - cache_data_type (128-bit).
  - The state enum.
  - Address-field widths and constants.
- Optional sub-module dcache_word_merge: combinational insert/extract of a 32-bit word into/out of a 128-bit line by addr[3:2].

Test Plan:
- Cold load 0x0000_0010, memory returns 0xDDDD_CCCC_BBBB_AAAA_..._44443333 after 3 cycles → one fill at 0x10 (rw=0). Tag[1]={1,0,0}. cpu_res_data = word 0 of the line; cpu_res_ready one cycle.
- Load 0x0000_0014 immediately after → hit, no mem_req_valid, response 2 cycles after acceptance with word 1.
- Store 0xCAFE_F00D to 0x0000_0018 → hit. Tag[1] dirty=1. Line word 2 = 0xCAFEF00D.
- Load 0x0000_0410 (same index 1, new tag 0x10) → WRITE_BACK to 0x10 with modified line (rw=1), then fill from 0x410. Tag[1]={1,0,0x10}.
- Assert reset_n=0 mid-ALLOCATE → next cycle state IDLE, mem_req_valid=0, cpu_res_ready=0. A subsequent request proceeds normally.
- With DCACHE_STATS_EN, run the above sequence → hits=2, misses=2, writebacks=1.

Source files
------------

// File: rtl/cache_def_pkg.sv
// Shared types and address-field widths for the data cache controller.
package cache_def_pkg;
   localparam int INDEX_BITS  = 2;
   localparam int OFFSET_BITS = 4;
   localparam int ADDR_BITS   = 32;
   localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
   localparam int LINE_BITS   = 128;
   localparam int WORD_BITS   = 32;

   typedef struct packed {
      logic [INDEX_BITS-1:0] index;
      logic                  we;
   } cache_req_type;

   typedef struct packed {
      logic                valid;
      logic                dirty;
      logic [TAG_BITS-1:0] tag;
   } cache_tag_type;

   typedef logic [LINE_BITS-1:0] cache_data_type;

   typedef enum logic [1:0] {IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE} cache_state_t;
endpackage

// File: rtl/dcache_word_merge.sv
// Extracts one 32-bit word from a 128-bit line, and builds the line with that word replaced.
module dcache_word_merge
   import cache_def_pkg::*;
(
   input  cache_data_type         line_i,
   input  logic [1:0]             sel_i,
   input  logic [WORD_BITS-1:0]   word_i,
   output logic [WORD_BITS-1:0]   word_o,
   output cache_data_type         line_o
);
   always_comb begin
      line_o = line_i;
      line_o[{sel_i, 5'b0} +: WORD_BITS] = word_i;
      word_o = line_i[{sel_i, 5'b0} +: WORD_BITS];
   end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Optional hit/miss/writeback counters under DCACHE_STATS_EN.
module dcache_ctrl
   import cache_def_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   cpu_req_valid,
   input  logic                   cpu_req_rw,
   input  logic [ADDR_BITS-1:0]   cpu_req_addr,
   input  logic [WORD_BITS-1:0]   cpu_req_data,
   output logic [WORD_BITS-1:0]   cpu_res_data,
   output logic                   cpu_res_ready,
   output logic                   mem_req_valid,
   output logic                   mem_req_rw,
   output logic [ADDR_BITS-1:0]   mem_req_addr,
   output cache_data_type         mem_req_data,
   input  logic                   mem_data_ready,
   input  cache_data_type         mem_data,
   output cache_req_type          data_req,
   output cache_data_type         data_write,
   input  cache_data_type         data_read,
   output cache_req_type          tag_req,
   output cache_tag_type          tag_write,
   input  cache_tag_type          tag_read
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]            stat_hits,
   output logic [31:0]            stat_misses,
   output logic [31:0]            stat_writebacks
`endif
);
   cache_state_t           state_q, state_d;
   logic                   rw_q;
   logic [ADDR_BITS-1:0]   addr_q;
   logic [WORD_BITS-1:0]   wdata_q;

   logic [INDEX_BITS-1:0]  req_idx;
   logic [TAG_BITS-1:0]    req_tag;
   logic                   hit;
   logic [WORD_BITS-1:0]   rd_word;
   cache_data_type         merged_line;

   assign req_idx = addr_q[OFFSET_BITS +: INDEX_BITS];
   assign req_tag = addr_q[ADDR_BITS-1 -: TAG_BITS];
   assign hit     = tag_read.valid && (tag_read.tag == req_tag);

   dcache_word_merge u_merge (
      .line_i (data_read),
      .sel_i  (addr_q[3:2]),
      .word_i (wdata_q),
      .word_o (rd_word),
      .line_o (merged_line)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && cpu_req_valid) begin
            rw_q    <= cpu_req_rw;
            addr_q  <= cpu_req_addr;
            wdata_q <= cpu_req_data;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      cpu_res_data  = '0;
      cpu_res_ready = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_rw    = 1'b0;
      mem_req_addr  = '0;
      mem_req_data  = '0;
      data_req      = '0;
      data_write    = '0;
      tag_req       = '0;
      tag_write     = '0;
      // Arrays are only addressed while a request is in flight; IDLE keeps every output at zero.
      if (state_q != IDLE) begin
         data_req.index = req_idx;
         tag_req.index  = req_idx;
      end
      case (state_q)
         IDLE: if (cpu_req_valid) state_d = COMPARE_TAG;
         COMPARE_TAG: begin
            if (hit) begin
               cpu_res_ready = 1'b1;
               if (rw_q) begin
                  data_write  = merged_line;
                  data_req.we = 1'b1;
                  tag_write   = '{valid: 1'b1, dirty: 1'b1, tag: req_tag};
                  tag_req.we  = 1'b1;
               end else begin
                  cpu_res_data = rd_word;
               end
               state_d = IDLE;
            end else if (tag_read.valid && tag_read.dirty) begin
               state_d = WRITE_BACK;
            end else begin
               state_d = ALLOCATE;
            end
         end
         WRITE_BACK: begin
            mem_req_valid = 1'b1;
            mem_req_rw    = 1'b1;
            mem_req_addr  = {tag_read.tag, req_idx, {OFFSET_BITS{1'b0}}};
            mem_req_data  = data_read;
            if (mem_data_ready) state_d = ALLOCATE;
         end
         ALLOCATE: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = {req_tag, req_idx, {OFFSET_BITS{1'b0}}};
            if (mem_data_ready) begin
               data_write  = mem_data;
               data_req.we = 1'b1;
               tag_write   = '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
               tag_req.we  = 1'b1;
               state_d     = COMPARE_TAG;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hits_q, misses_q, wbs_q;
   logic        retry_q;

   // retry_q marks the COMPARE that follows a fill so its guaranteed hit is not counted.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         hits_q   <= '0;
         misses_q <= '0;
         wbs_q    <= '0;
         retry_q  <= 1'b0;
      end else begin
         if (state_q == COMPARE_TAG && hit && !retry_q) hits_q <= hits_q + 32'd1;
         if (state_q == COMPARE_TAG && !hit)            misses_q <= misses_q + 32'd1;
         if (state_q == WRITE_BACK && mem_data_ready)   wbs_q <= wbs_q + 32'd1;
         if (state_q == ALLOCATE && mem_data_ready)     retry_q <= 1'b1;
         else if (state_q == IDLE)                      retry_q <= 1'b0;
      end
   end

   assign stat_hits       = hits_q;
   assign stat_misses     = misses_q;
   assign stat_writebacks = wbs_q;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with behavioural tag/data arrays and a fixed-latency memory.
module tb_dcache_ctrl;
   import cache_def_pkg::*;

   logic                 clock = 1'b0;
   logic                 reset_n;
   logic                 cpu_req_valid, cpu_req_rw;
   logic [31:0]          cpu_req_addr, cpu_req_data;
   logic [31:0]          cpu_res_data;
   logic                 cpu_res_ready;
   logic                 mem_req_valid, mem_req_rw;
   logic [31:0]          mem_req_addr;
   cache_data_type       mem_req_data;
   logic                 mem_data_ready = 1'b0;
   cache_data_type       mem_data = '0;
   cache_req_type        data_req, tag_req;
   cache_data_type       data_write, data_read;
   cache_tag_type        tag_write, tag_read;
`ifdef DCACHE_STATS_EN
   logic [31:0]          stat_hits, stat_misses, stat_writebacks;
`endif

   int total = 0;
   int bad   = 0;

   dcache_ctrl dut (
      .clock(clock), .reset_n(reset_n),
      .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
      .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
      .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
      .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_data_ready(mem_data_ready), .mem_data(mem_data),
      .data_req(data_req), .data_write(data_write), .data_read(data_read),
      .tag_req(tag_req), .tag_write(tag_write), .tag_read(tag_read)
`ifdef DCACHE_STATS_EN
      , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writebacks(stat_writebacks)
`endif
   );

   always #5 clock = ~clock;

   localparam cache_data_type BASE = {32'hDDDDCCCC, 32'hBBBBAAAA, 32'h66665555, 32'h44443333};

   cache_tag_type  tag_arr [4];
   cache_data_type data_arr[4];
   logic           arr_clr;

   assign tag_read  = tag_arr[tag_req.index];
   assign data_read = data_arr[data_req.index];

   always @(posedge clock) begin
      if (arr_clr) begin
         for (int i = 0; i < 4; i++) begin
            tag_arr[i]  <= '0;
            data_arr[i] <= '0;
         end
      end else begin
         if (tag_req.we)  tag_arr[tag_req.index]   <= tag_write;
         if (data_req.we) data_arr[data_req.index] <= data_write;
      end
   end

   // Memory answers in the third cycle of a request and logs every completed operation.
   int             mem_wait = 0;
   int             mem_ops  = 0;
   logic           log_rw  [8];
   logic [31:0]    log_addr[8];
   cache_data_type log_data[8];

   always @(posedge clock) begin
      mem_data_ready <= 1'b0;
      if (!mem_req_valid || mem_data_ready) begin
         mem_wait <= 0;
      end else begin
         mem_wait <= mem_wait + 1;
         if (mem_wait == 2) begin
            mem_data_ready <= 1'b1;
            mem_data       <= BASE ^ {4{mem_req_addr & 32'hFFFF_FF00}};
            if (mem_ops < 8) begin
               log_rw[mem_ops]   <= mem_req_rw;
               log_addr[mem_ops] <= mem_req_addr;
               log_data[mem_ops] <= mem_req_data;
            end
            mem_ops <= mem_ops + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issues one request and counts cycles from the accepting edge to cpu_res_ready (bounded).
   task automatic access(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                         output int n, output logic [31:0] rd);
      cpu_req_valid = 1'b1;
      cpu_req_rw    = rw;
      cpu_req_addr  = addr;
      cpu_req_data  = wd;
      tick();
      cpu_req_valid = 1'b0;
      n = 1;
      while (!cpu_res_ready && n < 50) begin
         tick();
         n++;
      end
      rd = cpu_res_data;
      tick();
   endtask

   int          n;
   logic [31:0] rd;

   initial begin
      reset_n = 1'b0; arr_clr = 1'b1;
      cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_data = '0;
      tick(); tick();
      check("rst_res_ready", cpu_res_ready, 1'b0);
      check("rst_mem_valid", mem_req_valid, 1'b0);
      check("rst_data_req", data_req, '0);
      check("rst_tag_req", tag_req, '0);
      reset_n = 1'b1; arr_clr = 1'b0;
      tick();

      // Cold load: clean miss, one fill
      access(1'b0, 32'h0000_0010, 32'h0, n, rd);
      check("cold_lat", n, 6);
      check("cold_data", rd, 32'h44443333);
      check("cold_res_pulse", cpu_res_ready, 1'b0);
      check("cold_mem_ops", mem_ops, 1);
      check("cold_fill_rw", log_rw[0], 1'b0);
      check("cold_fill_addr", log_addr[0], 32'h10);
      check("cold_tag", tag_arr[1], {1'b1, 1'b0, 26'h0});

      // Load hit
      access(1'b0, 32'h0000_0014, 32'h0, n, rd);
      check("hit_lat", n, 1);
      check("hit_data", rd, 32'h66665555);
      check("hit_no_mem", mem_ops, 1);

      // Store hit
      access(1'b1, 32'h0000_0018, 32'hCAFE_F00D, n, rd);
      check("st_lat", n, 1);
      check("st_tag", tag_arr[1], {1'b1, 1'b1, 26'h0});
      check("st_word", data_arr[1][95:64], 32'hCAFE_F00D);
      check("st_no_mem", mem_ops, 1);

      // Conflict load on index 1: writeback of dirty line then fill
      access(1'b0, 32'h0000_0410, 32'h0, n, rd);
      check("dirty_lat", n, 10);
      check("dirty_data", rd, 32'h44443733);
      check("dirty_mem_ops", mem_ops, 3);
      check("wb_rw", log_rw[1], 1'b1);
      check("wb_addr", log_addr[1], 32'h10);
      check("wb_data", log_data[1], {32'hDDDDCCCC, 32'hCAFEF00D, 32'h66665555, 32'h44443333});
      check("refill_rw", log_rw[2], 1'b0);
      check("refill_addr", log_addr[2], 32'h410);
      check("dirty_tag", tag_arr[1], {1'b1, 1'b0, 26'h10});
`ifdef DCACHE_STATS_EN
      check("stat_hits", stat_hits, 32'd2);
      check("stat_misses", stat_misses, 32'd2);
      check("stat_wbs", stat_writebacks, 32'd1);
`endif

      // Reset while in ALLOCATE
      cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0000_0020;
      tick();
      cpu_req_valid = 1'b0;
      tick();
      check("alloc_mem_valid", mem_req_valid, 1'b1);
      check("alloc_mem_addr", mem_req_addr, 32'h20);
      reset_n = 1'b0;
      tick();
      check("midrst_mem_valid", mem_req_valid, 1'b0);
      check("midrst_res_ready", cpu_res_ready, 1'b0);
`ifdef DCACHE_STATS_EN
      check("midrst_hits", stat_hits, 32'd0);
      check("midrst_misses", stat_misses, 32'd0);
`endif
      reset_n = 1'b1;
      tick();
      check("midrst_tag_untouched", tag_arr[2], '0);

      // Request after reset proceeds normally
      access(1'b0, 32'h0000_0024, 32'h0, n, rd);
      check("post_lat", n, 6);
      check("post_data", rd, 32'h66665555);
      check("post_fill_addr", log_addr[3], 32'h20);
      check("post_tag", tag_arr[2], {1'b1, 1'b0, 26'h0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
